// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// -----------------
// Bit-serial add/subtract unit. A single full adder is stepped over WIDTH
// clock cycles, LSB first, with a carry flip-flop closing the carry loop.
// One result is produced every WIDTH+1 cycles when start is held high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (all state cleared)
//   start      request a new operation (sampled in IDLE or DONE only)
//   a, b       WIDTH-bit operands, sampled with start
//   c_in       carry-in (add) / borrow-in (sub), sampled with start
//   sub        0: a+b+c_in, 1: a-b-c_in, sampled with start
//   busy       high while bits are being processed (state RUN)
//   done       one-cycle pulse when sum/c_out have just been updated
//   sum        result, held until the next completion
//   c_out      final carry (sub: 1 = no borrow), held with sum
//   state_dbg  current FSM state encoding (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a level request. It is accepted on any rising edge
// where the FSM is in IDLE or DONE; a, b, c_in and sub are captured on
// that same edge. There is no back-pressure on the result: done is a
// single-cycle pulse and sum/c_out stay valid until the next completion.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1, c1, c2;

    half_adder u_ha0 (.x(x),  .y(y),  .s(s1), .c(c1));
    half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_next, sum_q;
    logic             carry_q, c_out_q;
    logic [CW-1:0]    cnt_q;
    logic             load, last;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .ci(carry_q),
        .s (fa_s),
        .co(fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    // Written as shift/or so it stays valid for WIDTH=1.
    assign res_next = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Subtraction is a + ~b + ~c_in, so B is inverted and the
    // incoming borrow is flipped into a carry when the operands are loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= c_in ^ sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CW'(1);
            res_q   <= res_next;
            if (last) begin
                sum_q   <= res_next;
                c_out_q <= fa_co;
            end
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8).
// Driver tasks issue operations and push the reference result into exp_q;
// an independent monitor pops and compares on every done pulse.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] a, b;
  logic         c_in, sub;
  logic         busy, done, c_out;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .c_in(c_in),
    .sub(sub),
    .busy(busy),
    .done(done),
    .sum(sum),
    .c_out(c_out),
    .state_dbg(state_dbg)
  );

  // scoreboard
  logic [W:0] exp_q[$];   // {c_out, sum}
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Subtraction is a-b-c_in taken
  // modulo 2^W; c_out=1 means no borrow, i.e. a >= b + c_in.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    int r;
    if (!s) r = int'(x) + int'(y) + int'(ci);
    else    r = int'(x) - int'(y) - int'(ci) + (1 << W);
    return (W+1)'(r);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {23'd0, c_out, sum}, {23'd0, e});
      end
    end
  end

  // driver: set request at the current time, drop start one cycle later
  task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci, input logic si);
    start = 1'b1;
    a = ai;
    b = bi;
    c_in = ci;
    sub = si;
    exp_q.push_back(model(ai, bi, ci, si));
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns with the bench sitting on the negedge where done is high
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic quiet(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic run(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci, input logic si);
    int lat, bn;
    @(negedge clk);
    op(ai, bi, ci, si);
    wait_done(lat, bn);
    check("latency", lat, 9);
    @(negedge clk);
  endtask

  initial begin
    int lat, bn, cnt;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    sub = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", c_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic add with timing
    @(negedge clk);
    op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done(lat, bn);
    check("add_latency", lat, 9);
    check("add_busy_cycles", bn, 8);
    check("add_sum", sum, 8'h96);
    check("add_cout", c_out, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);

    // carry propagation and subtraction
    run(8'hFF, 8'h01, 1'b0, 1'b0);
    run(8'hFF, 8'hFF, 1'b1, 1'b0);
    run(8'h10, 8'h01, 1'b0, 1'b1);
    run(8'h01, 8'h02, 1'b0, 1'b1);
    check("sub_borrow_sum", sum, 8'hFF);
    check("sub_borrow_cout", c_out, 0);

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", c_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // start pulse and operand changes mid-RUN are ignored
    @(negedge clk);
    op(8'h33, 8'h44, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bn);
    check("ignore_mid_run_sum", sum, 8'h78);
    quiet(12, cnt);
    check("no_restart", cnt, 0);

    // back-to-back: start high during the done cycle
    @(negedge clk);
    op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(lat, bn);
    op(8'hC8, 8'h64, 1'b1, 1'b1);
    wait_done(lat, bn);
    check("b2b_gap", lat, 9);
    @(negedge clk);

    // abort during bit 4
    @(negedge clk);
    op(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet(12, cnt);
    check("abort_no_done", cnt, 0);
    check("abort_sum_held", sum, 0);
    run(8'h01, 8'h01, 1'b0, 1'b0);
    check("after_abort_sum", sum, 8'h02);

    // random operations, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(lat, bn);
      check("rand_latency", lat, 9);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
